uart_rx2: RTL and testbench

UART_RX2 -- requirements
Module: uart_rx2

---
 rtl/uart_rx2_if.sv | 34 +++
 rtl/uart_rx2.sv | 155 +++++++++++++++
 tb/tb_uart_rx2.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx2_if.sv
// uart_rx2_if: groups the serial line input and the receive results of uart_rx2.
// latency: none (wires only).
// backpressure: none; the results are pulses and must be taken in the cycle they appear.
//   RX_DATA   : asynchronous serial line, idle high (driven by the line side)
//   RX_BYTE   : last correctly framed byte, held until the next one
//   RX_DV     : one-cycle pulse when RX_BYTE updates
//   FRAME_ERR : one-cycle pulse when the stop bit is sampled low
//   BUSY      : high while the receiver is not idle
`timescale 1ns/1ps
interface uart_rx2_if;
    logic       RX_DATA;
    logic [7:0] RX_BYTE;
    logic       RX_DV;
    logic       FRAME_ERR;
    logic       BUSY;

    // line side / consumer of the results
    modport master (
        output RX_DATA,
        input  RX_BYTE,
        input  RX_DV,
        input  FRAME_ERR,
        input  BUSY
    );

    // receiver side
    modport slave (
        input  RX_DATA,
        output RX_BYTE,
        output RX_DV,
        output FRAME_ERR,
        output BUSY
    );
endinterface

// File: rtl/uart_rx2.sv
// uart_rx2: 8N1 UART receiver with mid-bit sampling and a 2-flop line synchronizer.
// latency: RX_DV / FRAME_ERR pulse one cycle after the stop-bit sample (line delayed 2 cycles).
// backpressure: none; each result is a single-cycle pulse, RX_BYTE holds until the next good frame.
//   CLK   : single clock, rising edge
//   RST_N : asynchronous active-low reset
//   rx    : uart_rx2_if.slave (RX_DATA in; RX_BYTE, RX_DV, FRAME_ERR, BUSY out)
`timescale 1ns/1ps
module uart_rx2 #(
    parameter int unsigned F_CLK        = 12_000_000,
    parameter int unsigned UART_BAUD    = 9600,
    parameter int unsigned CLKS_PER_BIT = F_CLK / UART_BAUD,
    parameter int unsigned STOP_BITS    = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    uart_rx2_if.slave  rx
);

    // Reject parameter sets the sampling scheme cannot handle.
    if (CLKS_PER_BIT < 4 || STOP_BITS < 1 || UART_BAUD == 0 || F_CLK == 0) begin : g_bad_param
        $error("uart_rx2: CLKS_PER_BIT must be >= 4 and STOP_BITS >= 1");
    end

    localparam logic [31:0] CPB_M1 = CLKS_PER_BIT - 1;
    localparam logic [31:0] HALF   = (CLKS_PER_BIT - 1) / 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    logic        rx_meta_q;
    logic        rx_s_q;
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        dv_q, dv_d;
    logic        ferr_q, ferr_d;

    // State register, including the synchronizer (reset to the idle line level).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx.RX_DATA;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                // Re-check the line half a bit in; a high level means the edge was a glitch.
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_DATA: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_STOP: begin
                // Only the first stop bit is checked; the rest overlap CLEANUP/IDLE so a
                // following start edge is never missed.
                if (cnt_q == CPB_M1) begin
                    cnt_d   = '0;
                    state_d = S_CLEANUP;
                    if (rx_s_q) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_CLEANUP: begin
                // Hold here through a break so a stuck-low line yields one error, not many.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        rx.RX_BYTE   = byte_q;
        rx.RX_DV     = dv_q;
        rx.FRAME_ERR = ferr_q;
        rx.BUSY      = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx2.sv
// tb_uart_rx2: randomized and directed frames against a frame-level reference model.
// latency: n/a (bench).
// backpressure: n/a (bench).
`timescale 1ns/1ps
module tb_uart_rx2;

    localparam int BIT_NS = 120;   // 12 clocks of 10 ns

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    uart_rx2_if bus();

    uart_rx2 #(
        .F_CLK     (12_000_000),
        .UART_BAUD (1_000_000)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .rx    (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: a frame whose first stop bit is high delivers its byte,
    // otherwise it counts as one framing error; RX_BYTE shows the last good byte.
    logic [7:0] exp_q[$];
    int         ferr_exp  = 0;
    logic [7:0] last_good = 8'h00;

    // Monitor of the DUT outputs, sampled on the falling edge.
    logic [7:0] got_q[$];
    int   ferr_seen   = 0;
    int   overlap_cnt = 0;
    int   dv_long     = 0;
    int   ferr_long   = 0;
    logic dv_prev     = 1'b0;
    logic ferr_prev   = 1'b0;

    always @(negedge CLK) begin
        if (RST_N) begin
            if (bus.RX_DV) got_q.push_back(bus.RX_BYTE);
            if (bus.FRAME_ERR) ferr_seen++;
            if (bus.RX_DV && bus.FRAME_ERR) overlap_cnt++;
            if (bus.RX_DV && dv_prev) dv_long++;
            if (bus.FRAME_ERR && ferr_prev) ferr_long++;
        end
        dv_prev   = bus.RX_DV;
        ferr_prev = bus.FRAME_ERR;
    end

    // Serial driver. A bad stop bit is held low for two bit times before the line
    // returns high, so the error is unambiguous even with a skewed bit period.
    task automatic send_frame(input logic [7:0] b, input int bit_ns,
                              input bit stop_ok, input int n_stop);
        bus.RX_DATA = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            bus.RX_DATA = b[i];
            #(bit_ns);
        end
        if (stop_ok) begin
            bus.RX_DATA = 1'b1;
            #(bit_ns * n_stop);
            exp_q.push_back(b);
            last_good = b;
        end else begin
            bus.RX_DATA = 1'b0;
            #(bit_ns * 2);
            bus.RX_DATA = 1'b1;
            #(bit_ns);
            ferr_exp++;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic compare_model(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        chk({tag, "_ferr"}, ferr_seen, ferr_exp);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
        end
        chk({tag, "_held"}, bus.RX_BYTE, last_good);
        chk({tag, "_busy"}, bus.BUSY, 1'b0);
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int         bit_ns;
        bit         ok;

        bus.RX_DATA = 1'b1;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_byte", bus.RX_BYTE, 8'h00);
        chk("rst_dv", bus.RX_DV, 1'b0);
        chk("rst_ferr", bus.FRAME_ERR, 1'b0);
        chk("rst_busy", bus.BUSY, 1'b0);
        RST_N = 1'b1;
        idle_cycles(5);

        // Single byte, two stop bits
        send_frame(8'hA5, BIT_NS, 1'b1, 2);
        idle_cycles(10);
        compare_model("a5");

        // Back-to-back, one stop bit: next start arrives right after the first stop bit
        send_frame(8'h3C, BIT_NS, 1'b1, 1);
        send_frame(8'hF0, BIT_NS, 1'b1, 1);
        idle_cycles(10);
        compare_model("b2b");

        // Three-cycle glitch on an idle line
        @(posedge CLK); #1 bus.RX_DATA = 1'b0;
        repeat (3) @(posedge CLK);
        #1 bus.RX_DATA = 1'b1;
        @(negedge CLK);
        chk("glitch_busy_start", bus.BUSY, 1'b1);
        idle_cycles(20);
        compare_model("glitch");

        // Stop bit low, line held low 40 more cycles, then high
        bus.RX_DATA = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            bus.RX_DATA = (8'h55 >> i) & 1'b1;
            #(BIT_NS);
        end
        bus.RX_DATA = 1'b0;
        #(BIT_NS);
        ferr_exp++;
        repeat (40) @(posedge CLK);
        chk("break_busy_low", bus.BUSY, 1'b1);
        @(posedge CLK); #1 bus.RX_DATA = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        chk("break_busy_hold", bus.BUSY, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        chk("break_busy_drop", bus.BUSY, 1'b0);
        idle_cycles(5);
        compare_model("break");
        send_frame(8'h81, BIT_NS, 1'b1, 2);
        idle_cycles(10);
        compare_model("after_break");

        // Reset asserted during data bit 4
        fork
            send_frame(8'hC3, BIT_NS, 1'b1, 2);
            begin
                #(BIT_NS * 5 + BIT_NS / 2);
                RST_N = 1'b0;
                #1;
                chk("midrst_byte", bus.RX_BYTE, 8'h00);
                chk("midrst_busy", bus.BUSY, 1'b0);
                chk("midrst_dv", bus.RX_DV, 1'b0);
            end
        join
        exp_q.delete();
        last_good = 8'h00;
        @(negedge CLK);
        chk("midrst_byte_hold", bus.RX_BYTE, 8'h00);
        RST_N = 1'b1;
        idle_cycles(5);
        compare_model("aborted");
        send_frame(8'h0F, BIT_NS, 1'b1, 2);
        idle_cycles(10);
        compare_model("after_rst");

        // Bit period skewed by -4% and +4%
        send_frame(8'h96, 115, 1'b1, 2);
        idle_cycles(10);
        compare_model("skew_fast");
        send_frame(8'h96, 125, 1'b1, 2);
        idle_cycles(10);
        compare_model("skew_slow");

        // Randomized frames: random byte, period, and occasional bad stop bit
        for (int n = 0; n < 16; n++) begin
            b      = 8'($urandom);
            bit_ns = int'($urandom_range(115, 125));
            ok     = ($urandom_range(0, 4) != 0);
            #($urandom_range(0, 9));
            send_frame(b, bit_ns, ok, 2);
            idle_cycles(10);
            compare_model("rand");
        end

        chk("dv_ferr_overlap", overlap_cnt, 0);
        chk("dv_width", dv_long, 0);
        chk("ferr_width", ferr_long, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
